// File: rtl/logic_pod_pkg.sv
// Shared types and widths for the logic-pod capture to DDR write path.
package logic_pod_pkg;
  localparam int LA_DATA_WIDTH = 128;
  localparam int LA_ADDR_WIDTH = 29;
  localparam int NUM_PODS      = 2;

  typedef enum logic [1:0] {IDLE, ADDR, CMD, DATA} arb_state_e;

  typedef struct packed {
    logic                     last;
    logic [LA_DATA_WIDTH-1:0] data;
  } wr_word_t;
endpackage

// File: rtl/logic_pod_wr_skid_buffer.sv
// Two-entry FIFO between the pod data FIFO read port and the DDR write stream.
module logic_pod_wr_skid_buffer
  import logic_pod_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  wr_word_t   push_word_i,
  input  logic       pop_i,
  output wr_word_t   head_o,
  output logic       valid_o,
  output logic [1:0] occ_o
);
  wr_word_t   mem_q [2];
  logic       wr_ptr_q, rd_ptr_q, valid_q;
  logic [1:0] occ_q, occ_d;
  logic       do_pop;

  assign do_pop = pop_i & valid_q;
  assign occ_d  = 2'(occ_q + {1'b0, push_i} - {1'b0, do_pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_word_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q   <= occ_d;
      valid_q <= (occ_d != 2'd0);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign occ_o   = occ_q;
endmodule

// File: rtl/logic_pod_ram_write_arbiter.sv
// Round-robins whole bursts from two logic-pod FIFO pairs onto one DDR command/write-data port.
module logic_pod_ram_write_arbiter
  import logic_pod_pkg::*;
#(
  parameter int BURST_WORDS = 8,
  parameter int ADDR_WIDTH  = LA_ADDR_WIDTH
) (
  input  logic                                    clk_ram_2x,
  input  logic                                    rst_n,
  input  logic                                    ram_ready,
  input  logic                                    enable,
  output logic [NUM_PODS-1:0]                     la_addr_rd_en,
  input  logic [NUM_PODS-1:0][ADDR_WIDTH-1:0]     la_addr_rd_data,
  input  logic [NUM_PODS-1:0][7:0]                la_addr_rd_size,
  output logic [NUM_PODS-1:0]                     la_data_rd_en,
  input  logic [NUM_PODS-1:0][LA_DATA_WIDTH-1:0]  la_data_rd_data,
  input  logic [NUM_PODS-1:0][9:0]                la_data_rd_size,
  output logic                                    cmd_valid,
  input  logic                                    cmd_ready,
  output logic [ADDR_WIDTH-1:0]                   cmd_addr,
  output logic                                    wr_valid,
  input  logic                                    wr_ready,
  output logic [LA_DATA_WIDTH-1:0]                wr_data,
  output logic                                    wr_last,
  output logic                                    busy,
  output logic [NUM_PODS-1:0][31:0]               burst_count
);
  localparam int             CW       = $clog2(BURST_WORDS) + 1;
  localparam logic [CW-1:0]  BURST    = CW'(BURST_WORDS);
  localparam logic [CW-1:0]  LAST_POP = CW'(BURST_WORDS - 1);

  arb_state_e                    state_q;
  logic                          grant_q, ptr_q, grant_d;
  logic [ADDR_WIDTH-1:0]         cmd_addr_q;
  logic [CW-1:0]                 pops_q;
  logic                          inflight_q, inflight_last_q;
  logic [NUM_PODS-1:0][31:0]     burst_cnt_q;
  logic [NUM_PODS-1:0]           elig;
  logic                          idle_go, data_pop, deq, buf_valid;
  logic [1:0]                    occ;
  logic [2:0]                    fill;
  wr_word_t                      head, push_word;

  for (genvar i = 0; i < NUM_PODS; i++) begin : g_elig
    assign elig[i] = (la_addr_rd_size[i] != 8'd0) && (la_data_rd_size[i] >= 10'(BURST_WORDS));
  end

  // Pointer pod wins ties; otherwise whichever pod is eligible.
  assign grant_d = elig[ptr_q] ? ptr_q : ~ptr_q;
  assign idle_go = (state_q == IDLE) && ram_ready && enable && (|elig);
  assign la_addr_rd_en = idle_go ? (NUM_PODS'(1) << grant_d) : '0;

  assign wr_valid = (state_q == DATA) && buf_valid;
  assign deq      = wr_valid && wr_ready;
  // Slots still claimed after this cycle's departure; a pop now lands next cycle.
  assign fill     = 3'({1'b0, occ} - {2'b0, deq} + {2'b0, inflight_q});
  assign data_pop = (state_q == DATA) && (pops_q < BURST) && (fill < 3'd2);
  assign la_data_rd_en = data_pop ? (NUM_PODS'(1) << grant_q) : '0;

  assign push_word = '{last: inflight_last_q, data: la_data_rd_data[grant_q]};

  logic_pod_wr_skid_buffer u_skid (
    .clk        (clk_ram_2x),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_word_i(push_word),
    .pop_i      (deq),
    .head_o     (head),
    .valid_o    (buf_valid),
    .occ_o      (occ)
  );

  always_ff @(posedge clk_ram_2x or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      grant_q         <= 1'b0;
      ptr_q           <= 1'b0;
      cmd_addr_q      <= '0;
      pops_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      burst_cnt_q     <= '0;
    end else begin
      inflight_q      <= data_pop;
      inflight_last_q <= data_pop && (pops_q == LAST_POP);
      case (state_q)
        IDLE: if (idle_go) begin
          grant_q <= grant_d;
          state_q <= ADDR;
        end
        ADDR: begin
          cmd_addr_q <= la_addr_rd_data[grant_q];
          state_q    <= CMD;
        end
        CMD: if (cmd_ready) begin
          pops_q  <= '0;
          state_q <= DATA;
        end
        DATA: begin
          if (data_pop) pops_q <= pops_q + CW'(1);
          if (deq && head.last) begin
            burst_cnt_q[grant_q] <= burst_cnt_q[grant_q] + 32'd1;
            ptr_q                <= ~grant_q;
            state_q              <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_valid   = (state_q == CMD);
  assign cmd_addr    = cmd_addr_q;
  assign wr_data     = head.data;
  assign wr_last     = head.last && wr_valid;
  assign busy        = (state_q != IDLE);
  assign burst_count = burst_cnt_q;
endmodule

// File: tb/tb_logic_pod_ram_write_arbiter.sv
// Random-stimulus bench: FIFO models per pod plus a burst-level scoreboard of the arbitration rules.
module tb_logic_pod_ram_write_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, ram_ready, enable, cmd_ready, wr_ready;
  logic [1:0]        la_addr_rd_en, la_data_rd_en;
  logic [1:0][28:0]  la_addr_rd_data;
  logic [1:0][7:0]   la_addr_rd_size;
  logic [1:0][127:0] la_data_rd_data;
  logic [1:0][9:0]   la_data_rd_size;
  logic              cmd_valid, wr_valid, wr_last, busy;
  logic [28:0]       cmd_addr;
  logic [127:0]      wr_data;
  logic [1:0][31:0]  burst_count;

  logic_pod_ram_write_arbiter #(.BURST_WORDS(8), .ADDR_WIDTH(29)) dut (
    .clk_ram_2x(clk), .rst_n(rst_n), .ram_ready(ram_ready), .enable(enable),
    .la_addr_rd_en(la_addr_rd_en), .la_addr_rd_data(la_addr_rd_data), .la_addr_rd_size(la_addr_rd_size),
    .la_data_rd_en(la_data_rd_en), .la_data_rd_data(la_data_rd_data), .la_data_rd_size(la_data_rd_size),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .busy(busy), .burst_count(burst_count)
  );

  // FIFO contents and the words each pod is expected to emit, in order
  logic [28:0]  aq0[$], aq1[$];
  logic [127:0] dq0[$], dq1[$], ex0[$], ex1[$];
  int grant_log[$];
  int n_cmp = 0, n_err = 0;
  int mdl_ptr, cur_pod, words, pops, cmd_low, cyc, first_cyc, last_cyc;
  int mdl_cnt[2], addr_pops[2], data_pops[2];
  bit cmd_done, wr_rand, cmd_hold, prev_cmd_stall, prev_wr_stall, prev_wr_last;
  logic [28:0]  exp_addr, prev_cmd_addr, last_cmd_addr;
  logic [127:0] prev_wr_data;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit elig(input int p);
    if (p == 0) return (aq0.size() != 0) && (dq0.size() >= 8);
    return (aq1.size() != 0) && (dq1.size() >= 8);
  endfunction

  task automatic upd_sizes();
    la_addr_rd_size[0] = 8'(aq0.size());
    la_addr_rd_size[1] = 8'(aq1.size());
    la_data_rd_size[0] = 10'(dq0.size());
    la_data_rd_size[1] = 10'(dq1.size());
  endtask

  task automatic push_addr(input int p, input logic [28:0] a);
    if (p == 0) aq0.push_back(a); else aq1.push_back(a);
    upd_sizes();
  endtask

  task automatic push_words(input int p, input int n);
    logic [127:0] w;
    for (int k = 0; k < n; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      if (p == 0) begin dq0.push_back(w); ex0.push_back(w); end
      else        begin dq1.push_back(w); ex1.push_back(w); end
    end
    upd_sizes();
  endtask

  task automatic push_burst(input int p, input logic [28:0] a);
    push_addr(p, a);
    push_words(p, 8);
  endtask

  task automatic clear_model();
    aq0.delete(); aq1.delete(); dq0.delete(); dq1.delete(); ex0.delete(); ex1.delete();
    mdl_ptr = 0; cur_pod = -1; words = 0; pops = 0; cmd_done = 0; cmd_low = 0;
    mdl_cnt[0] = 0; mdl_cnt[1] = 0;
    prev_cmd_stall = 0; prev_wr_stall = 0;
    la_addr_rd_data = '0; la_data_rd_data = '0;
    upd_sizes();
  endtask

  task automatic reset_checks();
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_last", wr_last, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_addr_en", la_addr_rd_en, 0);
    chk("rst_data_en", la_data_rd_en, 0);
    chk("rst_bcnt", burst_count, 0);
  endtask

  // One clock: observe at negedge, then update the FIFO models just after posedge.
  task automatic cycle();
    logic [1:0]   a_en, d_en;
    logic [127:0] e;
    bit e0, e1;
    int ep;
    @(negedge clk);
    cyc++;
    a_en = la_addr_rd_en; d_en = la_data_rd_en;
    e0 = elig(0); e1 = elig(1);
    chk("addr_en_onehot0", $onehot0(a_en), 1);
    chk("data_en_onehot0", $onehot0(d_en), 1);
    if (!busy) chk("idle_grant", |a_en, ram_ready && enable && (e0 || e1));
    if (a_en != 2'b00) begin
      ep = (mdl_ptr == 0) ? (e0 ? 0 : 1) : (e1 ? 1 : 0);
      cur_pod = a_en[1] ? 1 : 0;
      chk("grant_pod", cur_pod, ep);
      exp_addr = (cur_pod == 1) ? ((aq1.size() != 0) ? aq1[0] : 'x) : ((aq0.size() != 0) ? aq0[0] : 'x);
      words = 0; pops = 0; cmd_done = 0;
      grant_log.push_back(cur_pod);
      addr_pops[cur_pod]++;
      if (cmd_hold) cmd_low = 20;
    end
    if (prev_cmd_stall) begin
      chk("cmd_held", cmd_valid, 1);
      chk("cmd_addr_stable", cmd_addr, prev_cmd_addr);
    end
    if (cmd_valid && cmd_ready) begin
      chk("cmd_addr", cmd_addr, exp_addr);
      last_cmd_addr = cmd_addr;
      cmd_done = 1;
    end
    if (d_en != 2'b00) begin
      chk("pop_after_cmd", cmd_done, 1);
      chk("data_pod", d_en[1] ? 1 : 0, cur_pod);
      data_pops[d_en[1] ? 1 : 0]++;
      pops++;
      chk("pop_bound", pops <= 8, 1);
    end
    if (prev_wr_stall) begin
      chk("wr_held", wr_valid, 1);
      chk("wr_data_stable", wr_data, prev_wr_data);
      chk("wr_last_stable", wr_last, prev_wr_last);
    end
    if (wr_valid) begin
      chk("wr_in_data", cmd_done && cur_pod >= 0, 1);
      if (wr_ready && cur_pod >= 0) begin
        if (cur_pod == 0) e = (ex0.size() != 0) ? ex0.pop_front() : 'x;
        else              e = (ex1.size() != 0) ? ex1.pop_front() : 'x;
        chk("wr_data", wr_data, e);
        words++;
        if (words == 1) first_cyc = cyc;
        chk("wr_last", wr_last, words == 8);
        if (wr_last) begin
          last_cyc = cyc;
          chk("pops_per_burst", pops, 8);
          mdl_cnt[cur_pod]++;
          mdl_ptr = 1 - cur_pod;
          cur_pod = -1;
          cmd_done = 0;
        end
      end
    end
    prev_cmd_stall = cmd_valid && !cmd_ready; prev_cmd_addr = cmd_addr;
    prev_wr_stall  = wr_valid && !wr_ready;   prev_wr_data = wr_data; prev_wr_last = wr_last;
    @(posedge clk); #1;
    if (a_en[0]) begin chk("pop_empty_a0", aq0.size() != 0, 1); if (aq0.size() != 0) la_addr_rd_data[0] = aq0.pop_front(); end
    if (a_en[1]) begin chk("pop_empty_a1", aq1.size() != 0, 1); if (aq1.size() != 0) la_addr_rd_data[1] = aq1.pop_front(); end
    if (d_en[0]) begin chk("pop_empty_d0", dq0.size() != 0, 1); if (dq0.size() != 0) la_data_rd_data[0] = dq0.pop_front(); end
    if (d_en[1]) begin chk("pop_empty_d1", dq1.size() != 0, 1); if (dq1.size() != 0) la_data_rd_data[1] = dq1.pop_front(); end
    upd_sizes();
    wr_ready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cmd_low > 0) begin cmd_low--; cmd_ready = 1'b0; end
    else cmd_ready = 1'b1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((aq0.size() + aq1.size() != 0 || busy || cur_pod >= 0) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < max, 1);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_bcnt0"}, burst_count[0], mdl_cnt[0]);
    chk({tag, "_bcnt1"}, burst_count[1], mdl_cnt[1]);
  endtask

  initial begin
    int n, a0, d0, a1;
    rst_n = 1'b0; ram_ready = 1'b1; enable = 1'b1; wr_ready = 1'b1; cmd_ready = 1'b1;
    wr_rand = 0; cmd_hold = 0; cyc = 0;
    addr_pops[0] = 0; addr_pops[1] = 0; data_pops[0] = 0; data_pops[1] = 0;
    clear_model();
    #1;
    reset_checks();
    repeat (3) cycle();
    rst_n = 1'b1;

    // Both pods loaded with three bursts: strict alternation starting at pod 0
    for (int k = 0; k < 3; k++) begin
      push_burst(0, 29'(32'h1000 + k));
      push_burst(1, 29'(32'h2000 + k));
    end
    grant_log.delete();
    drain(500);
    chk("t2_ngrants", grant_log.size(), 6);
    for (int k = 0; k < 6; k++) chk("t2_grant", (k < grant_log.size()) ? grant_log[k] : -1, k % 2);
    chk("t2_bcnt0", burst_count[0], 3);
    chk("t2_bcnt1", burst_count[1], 3);

    // Single burst from pod 0 with wr_ready held high
    a0 = addr_pops[0]; d0 = data_pops[0];
    push_burst(0, 29'h0000100);
    drain(200);
    chk("t1_cmd_addr", last_cmd_addr, 29'h0000100);
    chk("t1_addr_pops", addr_pops[0] - a0, 1);
    chk("t1_data_pops", data_pops[0] - d0, 8);
    chk("t1_zero_bubble", last_cyc - first_cyc, 7);
    chk("t1_bcnt0", burst_count[0], 4);

    // Pod 1 one word short of a burst: must be ignored until the 8th word arrives
    a1 = addr_pops[1];
    push_addr(1, 29'h0000abc);
    push_words(1, 7);
    repeat (20) cycle();
    chk("t3_no_grant", addr_pops[1] - a1, 0);
    chk("t3_idle", busy, 0);
    push_words(1, 1);
    drain(200);
    chk("t3_granted", addr_pops[1] - a1, 1);
    check_counts("t3");

    // Random backpressure on both handshakes, random pod/address mix
    wr_rand = 1; cmd_hold = 1;
    for (int k = 0; k < 6; k++) push_burst(int'($urandom_range(0, 1)), 29'($urandom));
    drain(3000);
    check_counts("t4");
    wr_rand = 0; cmd_hold = 0;

    // enable drops mid-burst: burst finishes, then nothing until enable returns
    push_burst(0, 29'h0000200);
    push_burst(0, 29'h0000300);
    n = 0;
    while (!(cur_pod == 0 && words == 3) && n < 200) begin cycle(); n++; end
    chk("t5_reach_word3", n < 200, 1);
    enable = 1'b0;
    n = 0;
    while (cur_pod >= 0 && n < 200) begin cycle(); n++; end
    chk("t5_burst_done", n < 200, 1);
    a0 = addr_pops[0];
    repeat (20) cycle();
    chk("t5_no_grant", addr_pops[0] - a0, 0);
    chk("t5_idle", busy, 0);
    enable = 1'b1;
    drain(200);
    chk("t5_resumed", addr_pops[0] - a0, 1);
    check_counts("t5");

    // Reset in the middle of a pod 1 burst
    push_burst(1, 29'h0000400);
    n = 0;
    while (!(cur_pod == 1 && words == 2) && n < 200) begin cycle(); n++; end
    chk("t6_reach_word2", n < 200, 1);
    rst_n = 1'b0;
    #1;
    reset_checks();
    clear_model();
    repeat (3) cycle();
    rst_n = 1'b1;
    push_burst(0, 29'h0000500);
    push_burst(1, 29'h0000600);
    grant_log.delete();
    drain(300);
    chk("t6_first_grant", (grant_log.size() != 0) ? grant_log[0] : -1, 0);
    check_counts("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
